key_word_sched: RTL and testbench
=================================

KEY_WORD_SCHED -- requirements
Module: key_word_sched

Interface
REQ-001 Parameter NK, default 8, meaning key length in 32-bit words; legal values 4, 6, 8 (AES-128/192/256).
REQ-002 Parameter ROT_BYTES, default 1, meaning left byte-rotation applied by RotWord; legal 0..3.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  begin expansion; sampled only in IDLE.
REQ-006 key_in  input  32*NK  cipher key; w[0] in bits [32*NK-1 -: 32].
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 sub_req  output  1  SubWord request to the external S-box unit.
REQ-009 sub_word  output  32  SubWord operand; stable while sub_req high.
REQ-010 sub_ack  input  1  S-box response valid; completes the request.
REQ-011 sub_result  input  32  S-box result; sampled in the sub_ack cycle.
REQ-012 w_valid  output  1  one-cycle pulse per expanded word.
REQ-013 w_index  output  6  index i of the word on w_data.
REQ-014 w_data  output  32  expanded word w[i].
REQ-015 done  output  1  one-cycle pulse on completion.
REQ-016 rk_valid  output  1; rk_index  output  4; rk_data  output  128: round-key outputs (see Configuration).

Function
REQ-017 Total words TW = 4*(NK+7): 44, 52 or 60.
REQ-018 States: IDLE, LOAD, CALC, SUB_WAIT, FIN.
REQ-019 IDLE and start=1: key_in captured into an NK-word history register; next state LOAD.
REQ-020 LOAD: emits w[0..NK-1], one per cycle, w_valid=1, w_index=0..NK-1; after w[NK-1], go to CALC.
REQ-021 CALC for i, temp=w[i-1]: if i mod NK==0, operand = rotate-left(temp, 8*ROT_BYTES) and a SubWord is needed; else if NK==8 and i mod NK==4, operand=temp and a SubWord is needed; otherwise w[i]=w[i-NK] xor temp is emitted the next cycle (1 word/cycle).
REQ-022 When a SubWord is needed: sub_req=1 and sub_word=operand from the cycle after CALC; state SUB_WAIT.
REQ-023 SUB_WAIT: hold sub_req and sub_word until sub_ack=1. In the sub_ack cycle: sample sub_result; drop sub_req at the next edge; emit w[i] the following cycle. Then return to CALC. No timeout.
REQ-024 For i mod NK==0: w[i] = w[i-NK] xor sub_result xor {rcon,24'h0}. For NK==8, i mod 8==4: w[i] = w[i-8] xor sub_result.
REQ-025 rcon resets to 8'h01 at start. After each use it advances by xtime: shift left 1, xor 8'h1B if the old bit 7 was set. Sequence 01,02,04,08,10,20,40,80,1B,36.
REQ-026 After w[TW-1] is emitted, go to FIN. done=1 for one cycle, then IDLE.
REQ-027 sub_ack outside SUB_WAIT is ignored. start while busy is ignored.
REQ-028 History register is a shift register: each emitted word shifts in, the oldest word shifts out.

Reset
REQ-029 rst=1 at an edge: state goes to IDLE. busy, sub_req, w_valid, done and rk_valid go to 0. w_index, w_data, sub_word, rk_index and rk_data go to 0. rcon goes to 8'h01.
REQ-030 rst mid-expansion, including SUB_WAIT, aborts without emitting further words. A later sub_ack is ignored.
REQ-031 rst dominates a coincident start.

Configuration
REQ-032 Macro KEY_WORD_SCHED_ROUNDKEY_EN defined: each group of 4 consecutive words w[4k..4k+3] is packed MSB-first into rk_data. rk_valid pulses in the same cycle as the w_valid of w[4k+3], with rk_index=k (0..NK+6).
REQ-033 Macro undefined: the packing logic is absent and rk_valid, rk_index and rk_data are tied to 0.

Verification
REQ-034 NK=4, ROT_BYTES=1, key 2b7e1516 28aed2a6 abf71588 09cf4f3c, S-box model acking 1 cycle after req -> w[4]=a0fafe17, w[43]=b6630ca6, 44 w_valid pulses, done once.
REQ-035 NK=8, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> w[8]=9ba35411, w[59]=706c631e. Sub requests occur at i mod 8 in {0,4}: 13 requests in total.
REQ-036 NK=8, S-box ack delay randomised 0..5 cycles -> identical w sequence. sub_word stays stable throughout each request.
REQ-037 rst asserted in SUB_WAIT at i=12, then ack 2 cycles later -> all outputs 0, state IDLE, no w_valid. A new start gives a correct full sequence.
REQ-038 KEY_WORD_SCHED_ROUNDKEY_EN defined, NK=4 -> rk_index 0 gives rk_data=2b7e151628aed2a6abf7158809cf4f3c, and 11 rk_valid pulses. Macro undefined -> rk_valid never 1.

Source files
------------

// File: rtl/key_word_sched_if.sv
// key_word_sched_if: start/key, SubWord handshake and expanded-word bus
// of the AES key word scheduler.
interface key_word_sched_if #(
    parameter int NK = 8
);
    logic              start;
    logic [32*NK-1:0]  key_in;
    logic              busy;
    logic              sub_req;
    logic [31:0]       sub_word;
    logic              sub_ack;
    logic [31:0]       sub_result;
    logic              w_valid;
    logic [5:0]        w_index;
    logic [31:0]       w_data;
    logic              done;
    logic              rk_valid;
    logic [3:0]        rk_index;
    logic [127:0]      rk_data;

    modport slave (
        input  start, key_in, sub_ack, sub_result,
        output busy, sub_req, sub_word, w_valid, w_index, w_data, done,
               rk_valid, rk_index, rk_data
    );

    modport master (
        output start, key_in, sub_ack, sub_result,
        input  busy, sub_req, sub_word, w_valid, w_index, w_data, done,
               rk_valid, rk_index, rk_data
    );
endinterface

// File: rtl/key_word_sched.sv
// key_word_sched: AES key expansion, one word per cycle, SubWord via external S-box handshake.
// Optional round-key packing is enabled by defining KEY_WORD_SCHED_ROUNDKEY_EN.
module key_word_sched #(
    parameter int NK        = 8,
    parameter int ROT_BYTES = 1
) (
    input logic             clk,
    input logic             rst,
    key_word_sched_if.slave bus
);
    localparam int         TW       = 4 * (NK + 7);
    localparam logic [5:0] LAST_IDX = 6'(TW - 1);
    localparam logic [2:0] LAST_POS = 3'(NK - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD     = 3'd1;
    localparam logic [2:0] CALC     = 3'd2;
    localparam logic [2:0] SUB_WAIT = 3'd3;
    localparam logic [2:0] FIN      = 3'd4;

    logic [2:0]  state;
    logic [31:0] hist [NK];
    logic [5:0]  idx;
    logic [2:0]  pos;
    logic [7:0]  rcon;

    logic        sub_req_p1;
    logic [31:0] sub_word_p1;
    logic        vld_p1;
    logic [5:0]  index_p1;
    logic [31:0] data_p1;
    logic        done_p1;

    logic        need_sub;
    logic        emit;
    logic [31:0] operand;
    logic [31:0] emit_word;

    function automatic logic [31:0] rotword(input logic [31:0] x);
        logic [63:0] d;
        d = {x, x} >> (32 - 8 * ROT_BYTES);
        return d[31:0];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // hist[0] is w[i-NK], hist[NK-1] is w[i-1]; pos tracks i mod NK
    always_comb begin
        need_sub = 1'b0;
        operand  = hist[NK-1];
        if (pos == 3'd0) begin
            need_sub = 1'b1;
            operand  = rotword(hist[NK-1]);
        end else if (NK == 8 && pos == 3'd4) begin
            need_sub = 1'b1;
        end

        emit      = 1'b0;
        emit_word = hist[0] ^ hist[NK-1];
        case (state)
            LOAD: begin
                emit      = 1'b1;
                emit_word = hist[0];
            end
            CALC: emit = !need_sub;
            SUB_WAIT: begin
                if (bus.sub_ack) begin
                    emit      = 1'b1;
                    emit_word = hist[0] ^ bus.sub_result ^
                                {((pos == 3'd0) ? rcon : 8'h00), 24'h0};
                end
            end
            default: ;
        endcase
    end

    // Key capture, then every emitted word shifts in as the newest entry
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            for (int j = 0; j < NK; j++)
                hist[j] <= bus.key_in[32*NK-1-32*j -: 32];
        end else if (emit) begin
            for (int j = 0; j < NK - 1; j++)
                hist[j] <= hist[j+1];
            hist[NK-1] <= emit_word;
        end
    end

    // Stage boundary: registered word/handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= 6'd0;
            pos         <= 3'd0;
            rcon        <= 8'h01;
            sub_req_p1  <= 1'b0;
            sub_word_p1 <= 32'h0;
            vld_p1      <= 1'b0;
            index_p1    <= 6'd0;
            data_p1     <= 32'h0;
            done_p1     <= 1'b0;
        end else begin
            vld_p1  <= emit;
            done_p1 <= 1'b0;
            if (emit) begin
                data_p1  <= emit_word;
                index_p1 <= idx;
                idx      <= idx + 6'd1;
                pos      <= (pos == LAST_POS) ? 3'd0 : pos + 3'd1;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= LOAD;
                        rcon  <= 8'h01;
                        idx   <= 6'd0;
                        pos   <= 3'd0;
                    end
                end
                LOAD: if (pos == LAST_POS) state <= CALC;
                CALC: begin
                    if (need_sub) begin
                        sub_req_p1  <= 1'b1;
                        sub_word_p1 <= operand;
                        state       <= SUB_WAIT;
                    end else if (idx == LAST_IDX) begin
                        state <= FIN;
                    end
                end
                SUB_WAIT: begin
                    if (bus.sub_ack) begin
                        sub_req_p1 <= 1'b0;
                        if (pos == 3'd0) rcon <= xtime(rcon);
                        state <= (idx == LAST_IDX) ? FIN : CALC;
                    end
                end
                FIN: begin
                    done_p1 <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.sub_req  = sub_req_p1;
    assign bus.sub_word = sub_word_p1;
    assign bus.w_valid  = vld_p1;
    assign bus.w_index  = index_p1;
    assign bus.w_data   = data_p1;
    assign bus.done     = done_p1;

`ifdef KEY_WORD_SCHED_ROUNDKEY_EN
    logic [95:0]  rk_acc;
    logic         rk_vld_p1;
    logic [3:0]   rk_index_p1;
    logic [127:0] rk_data_p1;

    // Round key k is complete when w[4k+3] is emitted
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_vld_p1   <= 1'b0;
            rk_index_p1 <= 4'd0;
            rk_data_p1  <= 128'h0;
        end else begin
            rk_vld_p1 <= 1'b0;
            if (emit) begin
                rk_acc <= {rk_acc[63:0], emit_word};
                if (idx[1:0] == 2'd3) begin
                    rk_vld_p1   <= 1'b1;
                    rk_index_p1 <= idx[5:2];
                    rk_data_p1  <= {rk_acc, emit_word};
                end
            end
        end
    end

    assign bus.rk_valid = rk_vld_p1;
    assign bus.rk_index = rk_index_p1;
    assign bus.rk_data  = rk_data_p1;
`else
    assign bus.rk_valid = 1'b0;
    assign bus.rk_index = 4'd0;
    assign bus.rk_data  = 128'h0;
`endif
endmodule

// File: tb/tb_key_word_sched.sv
// tb_key_word_sched: NK=4 and NK=8 schedulers against a FIPS-197 style key expansion
// model, with an S-box responder giving randomized ack delays and stray acks.
module tb_key_word_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_word_sched_if #(.NK(4)) b4();
    key_word_sched_if #(.NK(8)) b8();

    key_word_sched #(.NK(4), .ROT_BYTES(1)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    key_word_sched #(.NK(8), .ROT_BYTES(1)) dut8 (.clk(clk), .rst(rst), .bus(b8));

    int checks = 0;
    int failures = 0;

    logic         ack_a [2];
    logic [31:0]  res_a [2];
    logic         man_en, man_ack;
    assign b4.sub_ack    = ack_a[0];
    assign b4.sub_result = res_a[0];
    assign b8.sub_ack    = man_en ? man_ack : ack_a[1];
    assign b8.sub_result = res_a[1];

    logic         req_a [2], wv_a [2], dn_a [2], rkv_a [2];
    logic [31:0]  sw_a [2], wd_a [2];
    logic [5:0]   wi_a [2];
    logic [3:0]   rki_a [2];
    logic [127:0] rkd_a [2];
    assign req_a[0] = b4.sub_req;  assign req_a[1] = b8.sub_req;
    assign sw_a[0]  = b4.sub_word; assign sw_a[1]  = b8.sub_word;
    assign wv_a[0]  = b4.w_valid;  assign wv_a[1]  = b8.w_valid;
    assign wi_a[0]  = b4.w_index;  assign wi_a[1]  = b8.w_index;
    assign wd_a[0]  = b4.w_data;   assign wd_a[1]  = b8.w_data;
    assign dn_a[0]  = b4.done;     assign dn_a[1]  = b8.done;
    assign rkv_a[0] = b4.rk_valid; assign rkv_a[1] = b8.rk_valid;
    assign rki_a[0] = b4.rk_index; assign rki_a[1] = b8.rk_index;
    assign rkd_a[0] = b4.rk_data;  assign rkd_a[1] = b8.rk_data;

    logic [7:0]   sbox [256];
    logic [31:0]  exp_w [60];
    int           exp_req;

    // Observation state, written only by the responder/monitor process
    logic [31:0]  got_w [2][256];
    logic [5:0]   got_i [2][256];
    int           got_n [2], req_n [2], done_n [2], rk_n [2], swbad [2], rkbad [2];
    logic [127:0] rk0 [2];
    logic         in_req [2];
    logic [31:0]  req_word [2];
    int           cnt [2], dly [2];

    // Stimulus configuration, written only by the main sequence
    bit           auto_en;
    int           dmin [2], dmax [2];
    int           bw, br, bd, bk, bs, bkb;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                      {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic model(input logic [255:0] key, input int nk);
        int rc;
        logic [31:0] t;
        rc = 1;
        exp_req = 0;
        for (int j = 0; j < nk; j++) exp_w[j] = key[32*nk-1-32*j -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = exp_w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc[7:0], 24'h0};
                rc = rc * 2;
                if (rc > 255) rc = rc ^ 'h11b;
                exp_req++;
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
                exp_req++;
            end
            exp_w[i] = exp_w[i-nk] ^ t;
        end
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            ack_a[d] = 1'b0; res_a[d] = 32'h0; in_req[d] = 1'b0; cnt[d] = 0; dly[d] = 0;
            got_n[d] = 0; req_n[d] = 0; done_n[d] = 0; rk_n[d] = 0; swbad[d] = 0; rkbad[d] = 0;
            rk0[d] = 128'h0; req_word[d] = 32'h0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                ack_a[d] = 1'b0;
                if (req_a[d]) begin
                    if (!in_req[d]) begin
                        in_req[d] = 1'b1; req_word[d] = sw_a[d]; cnt[d] = 0; req_n[d]++;
                        dly[d] = $urandom_range(dmax[d], dmin[d]);
                    end else if (sw_a[d] !== req_word[d]) swbad[d]++;
                    if (auto_en && cnt[d] == dly[d]) begin
                        ack_a[d] = 1'b1; res_a[d] = subw(sw_a[d]);
                    end
                    cnt[d]++;
                end else begin
                    in_req[d] = 1'b0;
                    if (auto_en && $urandom_range(3, 0) == 0) begin
                        ack_a[d] = 1'b1; res_a[d] = $urandom;
                    end
                end
                if (wv_a[d]) begin
                    got_w[d][got_n[d] % 256] = wd_a[d];
                    got_i[d][got_n[d] % 256] = wi_a[d];
                    got_n[d]++;
                end
                if (dn_a[d]) done_n[d]++;
                if (rkv_a[d]) begin
                    if (!wv_a[d] || wi_a[d][1:0] != 2'd3 || rki_a[d] != wi_a[d][5:2] ||
                        rkd_a[d] != {got_w[d][(got_n[d]+252)%256], got_w[d][(got_n[d]+253)%256],
                                     got_w[d][(got_n[d]+254)%256], got_w[d][(got_n[d]+255)%256]})
                        rkbad[d]++;
                    if (rki_a[d] == 4'd0) rk0[d] = rkd_a[d];
                    rk_n[d]++;
                end
            end
        end
    end

    task automatic snap(input int d);
        bw = got_n[d]; br = req_n[d]; bd = done_n[d]; bk = rk_n[d]; bs = swbad[d]; bkb = rkbad[d];
    endtask

    task automatic pulse_start(input int d);
        @(negedge clk);
        if (d == 0) b4.start = 1'b1; else b8.start = 1'b1;
        @(negedge clk);
        b4.start = 1'b0; b8.start = 1'b0;
    endtask

    task automatic wait_done(input int d, input string nm);
        int c;
        c = 0;
        while (done_n[d] == bd && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk({nm, "_done_seen"}, 32'(done_n[d] != bd), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_run(input int d, input int nk, input string nm);
        int tw;
        tw = 4 * (nk + 7);
        chk({nm, "_nwords"}, 32'(got_n[d] - bw), 32'(tw));
        for (int k = 0; k < tw; k++)
            chk($sformatf("%s_w%0d", nm, k),
                {got_i[d][(bw+k)%256], got_w[d][(bw+k)%256]}, {6'(k), exp_w[k]});
        chk({nm, "_nreq"}, 32'(req_n[d] - br), 32'(exp_req));
        chk({nm, "_ndone"}, 32'(done_n[d] - bd), 32'd1);
        chk({nm, "_subword_stable"}, 32'(swbad[d] - bs), 32'd0);
`ifdef KEY_WORD_SCHED_ROUNDKEY_EN
        chk({nm, "_nrk"}, 32'(rk_n[d] - bk), 32'(tw / 4));
        chk({nm, "_rk_content"}, 32'(rkbad[d] - bkb), 32'd0);
`else
        chk({nm, "_nrk"}, 32'(rk_n[d] - bk), 32'd0);
`endif
    endtask

    logic [255:0] key;
    int c;

    initial begin
        build_sbox();
        rst = 1'b1; man_en = 1'b0; man_ack = 1'b0; auto_en = 1'b0;
        b4.start = 1'b0; b8.start = 1'b0; b4.key_in = '0; b8.key_in = '0;
        dmin[0] = 1; dmax[0] = 1; dmin[1] = 0; dmax[1] = 5;
        repeat (3) @(negedge clk);
        chk("rst_ctl4", {b4.busy, b4.sub_req, b4.w_valid, b4.done, b4.rk_valid}, 0);
        chk("rst_data4", {b4.w_index, b4.w_data, b4.sub_word, b4.rk_index, b4.rk_data}, 0);
        chk("rst_ctl8", {b8.busy, b8.sub_req, b8.w_valid, b8.done, b8.rk_valid}, 0);
        chk("rst_data8", {b8.w_index, b8.w_data, b8.sub_word, b8.rk_index, b8.rk_data}, 0);

        // reset wins over a coincident start
        b4.start = 1'b1; b8.start = 1'b1;
        @(negedge clk);
        b4.start = 1'b0; b8.start = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("rst_vs_start4", b4.busy, 0);
        chk("rst_vs_start8", b8.busy, 0);
        auto_en = 1'b1;

        // NK=4 known-answer key, S-box ack one cycle after request, start ignored while busy
        key = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
        model(key, 4);
        snap(0);
        b4.key_in = key[127:0];
        pulse_start(0);
        chk("busy4", b4.busy, 1);
        b4.key_in = ~key[127:0];
        pulse_start(0);
        wait_done(0, "nk4");
        check_run(0, 4, "nk4");
        chk("nk4_kat_w4", got_w[0][(bw+4)%256], 32'ha0fafe17);
        chk("nk4_kat_w43", got_w[0][(bw+43)%256], 32'hb6630ca6);
        chk("idle4", b4.busy, 0);
`ifdef KEY_WORD_SCHED_ROUNDKEY_EN
        chk("nk4_rk0", rk0[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
`endif

        // NK=8 known-answer key with random ack delay 0..5
        key = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        model(key, 8);
        snap(1);
        b8.key_in = key;
        pulse_start(1);
        wait_done(1, "nk8");
        check_run(1, 8, "nk8");
        chk("nk8_kat_w8", got_w[1][(bw+8)%256], 32'h9ba35411);
        chk("nk8_kat_w59", got_w[1][(bw+59)%256], 32'h706c631e);

        // reset while waiting on the SubWord of w[12], then a late ack
        dmin[1] = 5; dmax[1] = 5;
        snap(1);
        pulse_start(1);
        c = 0;
        while (req_n[1] - br < 2 && c < 500) begin
            @(negedge clk);
            c++;
        end
        auto_en = 1'b0;
        chk("abort_reached_i12", 32'(req_n[1] - br), 32'd2);
        chk("abort_sub_req", b8.sub_req, 1);
        chk("abort_sub_word", b8.sub_word, exp_w[11]);
        chk("abort_words_before", 32'(got_n[1] - bw), 32'd12);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        man_en = 1'b1; man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0; man_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_ctl8", {b8.busy, b8.sub_req, b8.w_valid, b8.done, b8.rk_valid}, 0);
        chk("abort_data8", {b8.w_index, b8.w_data, b8.sub_word, b8.rk_index, b8.rk_data}, 0);
        chk("abort_no_words", 32'(got_n[1] - bw), 32'd12);
        chk("abort_no_done", 32'(done_n[1] - bd), 32'd0);

        // fresh random key after the abort
        auto_en = 1'b1; dmin[1] = 0; dmax[1] = 2;
        for (int j = 0; j < 8; j++) key[32*j +: 32] = $urandom;
        model(key, 8);
        snap(1);
        b8.key_in = key;
        pulse_start(1);
        wait_done(1, "nk8r");
        check_run(1, 8, "nk8r");

        // NK=4 random key with random delays
        dmin[0] = 0; dmax[0] = 5;
        key = '0;
        for (int j = 0; j < 4; j++) key[32*j +: 32] = $urandom;
        model(key, 4);
        snap(0);
        b4.key_in = key[127:0];
        pulse_start(0);
        wait_done(0, "nk4r");
        check_run(0, 4, "nk4r");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
